// File: rtl/sigma_delta_dac.sv
// rtl/sigma_delta_dac.sv - first-order error-feedback 1-bit sigma-delta DAC
// The carry out of a W-bit accumulator becomes the pulse-density output bit.
`timescale 1ns/1ps
module sigma_delta_dac #(
  parameter int W         = 16,
  parameter int SIGNED_IN = 0
) (
  input  logic         clk_i,
  input  logic         res_i,
  input  logic [W-1:0] dac_i,
  output logic         dac_o
);

  logic [W-1:0] d;
  logic [W-1:0] acc;
  logic [W:0]   sum;

  // Two's complement input is shifted to offset binary by flipping the MSB.
  generate
    if (SIGNED_IN != 0) begin : g_signed
      always_comb d = {~dac_i[W-1], dac_i[W-2:0]};
    end else begin : g_unsigned
      always_comb d = dac_i;
    end
  endgenerate

  always_comb sum = {1'b0, acc} + {1'b0, d};

  // acc wraps mod 2^W; the carry out is the emitted bit.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      acc   <= '0;
      dac_o <= 1'b0;
    end else begin
      acc   <= sum[W-1:0];
      dac_o <= sum[W];
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb/tb_sigma_delta_dac.sv - scoreboard bench for sigma_delta_dac (unsigned and signed instances)
`timescale 1ns/1ps
module tb_sigma_delta_dac;
  localparam int W = 10;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         res;
  logic [W-1:0] dac_u;
  logic [W-1:0] dac_s;
  logic         out_u;
  logic         out_s;

  sigma_delta_dac #(.W(W), .SIGNED_IN(0)) dut_u (
    .clk_i(clk), .res_i(res), .dac_i(dac_u), .dac_o(out_u)
  );
  sigma_delta_dac #(.W(W), .SIGNED_IN(1)) dut_s (
    .clk_i(clk), .res_i(res), .dac_i(dac_s), .dac_o(out_s)
  );

  typedef struct packed {
    logic u;
    logic s;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_u  = 0;
  int          acc_s  = 0;
  int          ones_u = 0;
  int          ones_s = 0;
  logic [15:0] hist_u = '0;
  logic [15:0] hist_s = '0;
  bit          done   = 1'b0;

  // Signed sample as a level on the 0..2^W-1 scale.
  function automatic int sval(input logic [W-1:0] x);
    return int'($signed(x)) + M / 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: integer accumulator; output is 1 whenever the sum reaches 2^W.
  task automatic cyc(input logic r, input logic [W-1:0] du, input logic [W-1:0] ds);
    exp_t e;
    int   su;
    int   ss;
    res   = r;
    dac_u = du;
    dac_s = ds;
    if (r) begin
      acc_u = 0;
      acc_s = 0;
      e.u   = 1'b0;
      e.s   = 1'b0;
    end else begin
      su    = acc_u + int'(du);
      ss    = acc_s + sval(ds);
      e.u   = (su >= M);
      e.s   = (ss >= M);
      acc_u = su % M;
      acc_s = ss % M;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!done) begin
          errors++;
          $display("FAIL queue_underflow: got 0 entries expected 1");
        end
      end else begin
        e = exp_q.pop_front();
        check("dac_o_unsigned", {31'd0, out_u}, {31'd0, e.u});
        check("dac_o_signed", {31'd0, out_s}, {31'd0, e.s});
        hist_u = {hist_u[14:0], out_u};
        hist_s = {hist_s[14:0], out_s};
        ones_u += int'(out_u);
        ones_s += int'(out_s);
      end
    end
  end

  initial begin
    logic [W-1:0] du;
    logic [W-1:0] ds;
    res   = 1'b1;
    dac_u = '0;
    dac_s = '0;

    // Zero input after a two-cycle reset
    cyc(1'b1, '0, '0);
    cyc(1'b1, '0, '0);
    check("reset_out_u", {31'd0, out_u}, 32'd0);
    check("reset_out_s", {31'd0, out_s}, 32'd0);
    ones_u = 0;
    repeat (1000) cyc(1'b0, '0, '0);
    check("zero_ones", ones_u, 32'd0);

    // Half scale (unsigned) and signed zero: 0,1,0,1,... after reset
    cyc(1'b1, W'(M / 2), '0);
    ones_u = 0;
    ones_s = 0;
    repeat (4) cyc(1'b0, W'(M / 2), '0);
    check("half_seq_u", {27'd0, hist_u[4:0]}, 32'b00101);
    check("half_seq_s", {27'd0, hist_s[4:0]}, 32'b00101);
    repeat (M - 4) cyc(1'b0, W'(M / 2), '0);
    check("half_ones_u", ones_u, M / 2);
    check("half_ones_s", ones_s, M / 2);

    // Full scale and minimum unsigned, most negative signed, from arbitrary acc
    ones_u = 0;
    ones_s = 0;
    repeat (M) cyc(1'b0, W'(M - 1), W'(M / 2));
    check("max_ones_u", ones_u, M - 1);
    check("neg_ones_s", ones_s, 32'd0);
    ones_u = 0;
    repeat (M) cyc(1'b0, W'(1), W'(M / 2));
    check("min_ones_u", ones_u, 32'd1);

    // Reset mid-stream: output restarts at 0,0,0,1,... for quarter scale
    repeat (12345) cyc(1'b0, W'(M / 4), W'($urandom_range(0, M - 1)));
    cyc(1'b1, W'(M / 4), W'($urandom_range(0, M - 1)));
    check("midreset_out_u", {31'd0, out_u}, 32'd0);
    check("midreset_out_s", {31'd0, out_s}, 32'd0);
    repeat (8) cyc(1'b0, W'(M / 4), W'(M / 4));
    check("quarter_seq_u", {23'd0, hist_u[8:0]}, 32'b000010001);

    // Random sweeps: held for 3 full periods, no reset between them
    for (int k = 0; k < 6; k++) begin
      du     = W'($urandom_range(0, M - 1));
      ds     = W'($urandom_range(0, M - 1));
      ones_u = 0;
      ones_s = 0;
      repeat (3 * M) cyc(1'b0, du, ds);
      check("sweep_ones_u", ones_u, 3 * int'(du));
      check("sweep_ones_s", ones_s, 3 * sval(ds));
    end

    done = 1'b1;
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
